// File: rtl/st_drain_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | st_drain_buf_pkg : shared widths, drain FSM states, conflict match  |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
package st_drain_buf_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } sdb_state_t;

  // Two stores conflict when they touch the same doubleword and share a byte lane.
  function automatic logic dword_conflict(
    input logic [ADDR_W-1:0] a_addr,
    input logic [STRB_W-1:0] a_strb,
    input logic [ADDR_W-1:0] b_addr,
    input logic [STRB_W-1:0] b_strb
  );
    return (a_addr[ADDR_W-1:3] == b_addr[ADDR_W-1:3]) && ((a_strb & b_strb) != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/st_drain_buf_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | st_drain_buf_if : enqueue, memory store, response and query bundle  |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
interface st_drain_buf_if #(
  parameter int DEPTH = 4
);
  import st_drain_buf_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_wdata;
  logic [STRB_W-1:0] enq_wstrb;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_wdata;
  logic [STRB_W-1:0] st_wstrb;

  logic              st_resp_valid;
  logic              st_resp_ready;

  logic [ADDR_W-1:0] chk_addr;
  logic [STRB_W-1:0] chk_wstrb;
  logic              chk_hit;

  logic [CNT_W-1:0]  count;
  logic              drained;

  modport master (
    output enq_valid, enq_addr, enq_wdata, enq_wstrb,
    input  enq_ready,
    input  st_valid, st_addr, st_wdata, st_wstrb,
    output st_ready,
    output st_resp_valid,
    input  st_resp_ready,
    output chk_addr, chk_wstrb,
    input  chk_hit,
    input  count, drained
  );

  modport slave (
    input  enq_valid, enq_addr, enq_wdata, enq_wstrb,
    output enq_ready,
    output st_valid, st_addr, st_wdata, st_wstrb,
    input  st_ready,
    input  st_resp_valid,
    output st_resp_ready,
    input  chk_addr, chk_wstrb,
    output chk_hit,
    output count, drained
  );

endinterface
`default_nettype wire

// File: rtl/st_drain_buf_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdb_fifo : store-buffer storage, wrapping pointers, count, valids   |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module sdb_fifo
  import st_drain_buf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic [STRB_W-1:0]             push_strb,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [STRB_W-1:0]             head_strb,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr,
  output logic [DEPTH-1:0][STRB_W-1:0]  ent_strb,
  output logic [CNT_W-1:0]              count
);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0][STRB_W-1:0] strb_q;
  logic [DEPTH-1:0]             valid_q;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic                         do_push;
  logic                         do_pop;

  // Local guards keep count inside [0, DEPTH] regardless of the caller.
  assign do_push = push && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        valid_q[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        valid_q[rd_ptr] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
      strb_q[wr_ptr] <= push_strb;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_strb = strb_q[rd_ptr];
  assign ent_valid = valid_q;
  assign ent_addr  = addr_q;
  assign ent_strb  = strb_q;

endmodule
`default_nettype wire

// File: rtl/st_drain_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | st_drain_buf : in-order store drain with one outstanding store and  |
// | load-conflict lookup.  Revision: 1.0                                 |
// +--------------------------------------------------------------------+
module st_drain_buf
  import st_drain_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  st_drain_buf_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  sdb_state_t                   state;
  sdb_state_t                   state_nxt;
  logic                         enq_ready;
  logic                         push;
  logic                         pop;
  logic                         st_valid;
  logic                         st_resp_ready;
  logic [CNT_W-1:0]             count;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [STRB_W-1:0]            head_strb;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][STRB_W-1:0] ent_strb;
  logic [DEPTH-1:0]             hit_vec;

  // Registered count only: a same-cycle pop never opens a slot.
  assign enq_ready = count < CNT_W'(DEPTH);
  assign push      = bus.enq_valid && enq_ready && (bus.enq_wstrb != '0);
  assign pop       = (state == WAIT_RESP) && bus.st_resp_valid;

  sdb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_addr (bus.enq_addr),
    .push_data (bus.enq_wdata),
    .push_strb (bus.enq_wstrb),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_strb (head_strb),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_strb  (ent_strb),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The head stays in the FIFO through WAIT_RESP so it remains visible to chk_hit.
  always_comb begin
    state_nxt     = state;
    st_valid      = 1'b0;
    st_resp_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != '0) || push) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        st_valid = 1'b1;
        if (bus.st_ready) begin
          state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        st_resp_ready = 1'b1;
        if (bus.st_resp_valid) begin
          state_nxt = ((count > CNT_W'(1)) || push) ? ISSUE : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_chk
    assign hit_vec[i] = ent_valid[i] &&
                        dword_conflict(ent_addr[i], ent_strb[i], bus.chk_addr, bus.chk_wstrb);
  end

  assign bus.enq_ready     = enq_ready;
  assign bus.st_valid      = st_valid;
  assign bus.st_addr       = st_valid ? head_addr : '0;
  assign bus.st_wdata      = st_valid ? head_data : '0;
  assign bus.st_wstrb      = st_valid ? head_strb : '0;
  assign bus.st_resp_ready = st_resp_ready;
  assign bus.chk_hit       = |hit_vec;
  assign bus.count         = count;
  assign bus.drained       = (count == '0) && (state == IDLE);

endmodule
`default_nettype wire
